// File: rtl/usb_tx_arb_pkg.sv
// Shared types and helpers for the USB TX wire arbiters.
package usb_tx_arb_pkg;

  typedef enum logic [1:0] {
    ARB_INIT  = 2'd0,
    ARB_IDLE  = 2'd1,
    ARB_GRANT = 2'd2
  } arbState_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usb_tx_arb_if.sv
// Requester-side and wire-side signals of the N-way USB TX wire arbiter.
interface usb_tx_arb_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 2
);
  import usb_tx_arb_pkg::*;

  localparam int unsigned IDX_W = idxWidth(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        in_wen;
  logic [NUM_REQ*DATA_W-1:0] in_data;
  logic [NUM_REQ-1:0]        in_ctl;
  logic [NUM_REQ-1:0]        in_fsrate;
  logic                      wire_rdy_in;
  logic                      wire_rdy_out;
  logic                      wire_wen;
  logic [DATA_W-1:0]         tx_bits;
  logic                      tx_ctl;
  logic                      tx_fsrate;
  logic [IDX_W-1:0]          owner;
  logic                      hold_timeout;

  modport master (
    input  req, in_wen, in_data, in_ctl, in_fsrate, wire_rdy_in,
    output gnt, wire_rdy_out, wire_wen, tx_bits, tx_ctl, tx_fsrate, owner, hold_timeout
  );

  modport slave (
    output req, in_wen, in_data, in_ctl, in_fsrate, wire_rdy_in,
    input  gnt, wire_rdy_out, wire_wen, tx_bits, tx_ctl, tx_fsrate, owner, hold_timeout
  );

endinterface

// File: rtl/usb_arb_pick.sv
// Combinational winner picker: fixed priority from index 0, or round-robin after ptr.
module usb_arb_pick
  import usb_tx_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  parameter  int unsigned POLICY  = ARB_FIXED,
  localparam int unsigned IDX_W   = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Rotated scan; the pointer itself is visited last in round-robin mode.
  always_comb begin
    int unsigned start;
    int unsigned idx;
    winner = '0;
    valid  = 1'b0;
    start  = (POLICY == ARB_RR) ? (32'(ptr) + 32'd1) : 32'd0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (start + k) % NUM_REQ;
      if (!valid && elig[IDX_W'(idx)]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/usb_tx_wire_arb_n.sv
// N-way arbiter for the shared USB TX wire: grant FSM, hold timeout with
// owner lockout, and the owner-selected mux towards the wire TX block.
module usb_tx_wire_arb_n
  import usb_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DATA_W      = 2,
  parameter int unsigned ROUND_ROBIN = 0,
  parameter int unsigned MAX_HOLD    = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  usb_tx_arb_if.master bus
);

  localparam int unsigned      IDX_W     = idxWidth(NUM_REQ);
  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arbState_t          state;
  logic [NUM_REQ-1:0] lockout;
  logic [NUM_REQ-1:0] elig;
  logic [CNT_W-1:0]   holdCnt;
  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W-1:0]   winner;
  logic               winValid;
  logic               ownerReq;
  logic [DATA_W-1:0]  bitsArr [NUM_REQ];

  assign elig     = bus.req & ~lockout;
  assign ownerReq = bus.req[bus.owner];

  usb_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .POLICY  ((ROUND_ROBIN != 0) ? ARB_RR : ARB_FIXED)
  ) uPick (
    .elig   (elig),
    .ptr    (rrPtr),
    .winner (winner),
    .valid  (winValid)
  );

  // Grant FSM; a lockout bit survives only while its requester keeps req high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ARB_INIT;
      bus.gnt          <= '0;
      bus.owner        <= '0;
      bus.hold_timeout <= 1'b0;
      holdCnt          <= '0;
      lockout          <= '0;
      rrPtr            <= '0;
    end else begin
      bus.hold_timeout <= 1'b0;
      lockout          <= lockout & bus.req;
      case (state)
        ARB_INIT: state <= ARB_IDLE;
        ARB_IDLE: begin
          if (winValid) begin
            bus.gnt   <= NUM_REQ'(1) << winner;
            bus.owner <= winner;
            holdCnt   <= '0;
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!ownerReq) begin
            bus.gnt <= '0;
            state   <= ARB_IDLE;
            if (ROUND_ROBIN != 0) rrPtr <= bus.owner;
          end else if (HOLD_EN && (holdCnt == HOLD_LAST)) begin
            bus.gnt          <= '0;
            bus.hold_timeout <= 1'b1;
            lockout          <= (lockout & bus.req) | (NUM_REQ'(1) << bus.owner);
            rrPtr            <= bus.owner;
            state            <= ARB_IDLE;
          end else if (holdCnt != '1) begin
            holdCnt <= holdCnt + CNT_W'(1);
          end
        end
        default: state <= ARB_INIT;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : gSplit
    assign bitsArr[i] = bus.in_data[i*DATA_W +: DATA_W];
  end

  // Mux follows the registered owner even while idle; only the write enable is gated.
  assign bus.tx_bits      = bitsArr[bus.owner];
  assign bus.tx_ctl       = bus.in_ctl[bus.owner];
  assign bus.tx_fsrate    = bus.in_fsrate[bus.owner];
  assign bus.wire_wen     = bus.in_wen[bus.owner] & (|bus.gnt);
  assign bus.wire_rdy_out = bus.wire_rdy_in;

endmodule

// File: tb/tb_usb_tx_wire_arb_n.sv
// Self-checking bench: a 2-way fixed-priority arbiter and a 4-way round-robin
// arbiter with a 5-cycle hold limit, checked against a behavioural model.
module tb_usb_tx_wire_arb_n;

  logic clk = 1'b0;
  logic rst;
  logic armed = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;

  always #5 clk = ~clk;

  usb_tx_arb_if #(.NUM_REQ(2), .DATA_W(2)) ifA ();
  usb_tx_arb_if #(.NUM_REQ(4), .DATA_W(2)) ifB ();

  usb_tx_wire_arb_n #(.NUM_REQ(2), .DATA_W(2), .ROUND_ROBIN(0), .MAX_HOLD(0), .CNT_W(16))
    dutA (.clk(clk), .rst(rst), .bus(ifA.master));
  usb_tx_wire_arb_n #(.NUM_REQ(4), .DATA_W(2), .ROUND_ROBIN(1), .MAX_HOLD(5), .CNT_W(16))
    dutB (.clk(clk), .rst(rst), .bus(ifB.master));

  // Model: 'held' counts cycles the grant has been visible so far.
  typedef struct packed {
    bit       inited;
    bit       busy;
    int       own;
    int       held;
    bit [7:0] lock;
    int       ptr;
    bit       to;
  } mdl_t;

  mdl_t mA = '0;
  mdl_t mB = '0;

  function automatic mdl_t mstep(input mdl_t m, input bit [7:0] req, input int n,
                                 input bit rr, input int maxHold, input bit r);
    mdl_t     x;
    bit [7:0] elig;
    int       i;
    x    = m;
    x.to = 1'b0;
    if (r) begin
      x = '0;
      return x;
    end
    if (!m.inited) begin
      x.inited = 1'b1;
      return x;
    end
    x.lock = m.lock & req;
    if (!m.busy) begin
      elig = req & ~m.lock;
      for (int k = 0; k < n; k++) begin
        i = rr ? (m.ptr + 1 + k) % n : k;
        if (!x.busy && elig[i]) begin
          x.busy = 1'b1;
          x.own  = i;
          x.held = 1;
        end
      end
    end else if (!req[m.own]) begin
      x.busy = 1'b0;
      if (rr) x.ptr = m.own;
    end else if (maxHold != 0 && m.held == maxHold) begin
      x.busy        = 1'b0;
      x.to          = 1'b1;
      x.lock[m.own] = 1'b1;
      x.ptr         = m.own;
    end else begin
      x.held = m.held + 1;
    end
    return x;
  endfunction

  always @(posedge clk) begin
    mA <= mstep(mA, 8'(ifA.req), 2, 1'b0, 0, rst);
    mB <= mstep(mB, 8'(ifB.req), 4, 1'b1, 5, rst);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmpOne(input string tag, input mdl_t m, input logic [7:0] gnt,
                        input logic [31:0] owner, input logic to, input logic [31:0] bits,
                        input logic ctl, input logic fs, input logic wen,
                        input logic rdyo, input logic rdyi, input logic [7:0] inWen,
                        input logic [15:0] inData, input logic [7:0] inCtl,
                        input logic [7:0] inFs);
    logic [7:0] expG;
    expG = m.busy ? 8'(1 << m.own) : 8'd0;
    chk({tag, "gnt"},          32'(gnt), 32'(expG));
    chk({tag, "owner"},        owner, 32'(m.own));
    chk({tag, "hold_timeout"}, 32'(to), 32'(m.to));
    chk({tag, "tx_bits"},      bits, 32'((inData >> (2 * m.own)) & 16'h3));
    chk({tag, "tx_ctl"},       32'(ctl), 32'(inCtl[m.own]));
    chk({tag, "tx_fsrate"},    32'(fs), 32'(inFs[m.own]));
    chk({tag, "wire_wen"},     32'(wen), 32'(m.busy & inWen[m.own]));
    chk({tag, "wire_rdy_out"}, 32'(rdyo), 32'(rdyi));
    chk({tag, "gnt_onehot0"},  32'($countones(gnt) <= 1), 32'd1);
  endtask

  // Every cycle once reset has been applied, compare both arbiters to the model.
  always @(negedge clk) begin
    if (armed) begin
      cmpOne("A_", mA, 8'(ifA.gnt), 32'(ifA.owner), ifA.hold_timeout, 32'(ifA.tx_bits),
             ifA.tx_ctl, ifA.tx_fsrate, ifA.wire_wen, ifA.wire_rdy_out, ifA.wire_rdy_in,
             8'(ifA.in_wen), 16'(ifA.in_data), 8'(ifA.in_ctl), 8'(ifA.in_fsrate));
      cmpOne("B_", mB, 8'(ifB.gnt), 32'(ifB.owner), ifB.hold_timeout, 32'(ifB.tx_bits),
             ifB.tx_ctl, ifB.tx_fsrate, ifB.wire_wen, ifB.wire_rdy_out, ifB.wire_rdy_in,
             8'(ifB.in_wen), 16'(ifB.in_data), 8'(ifB.in_ctl), 8'(ifB.in_fsrate));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    ifA.req = '0; ifA.in_wen = '0; ifA.in_data = '0; ifA.in_ctl = '0; ifA.in_fsrate = '0;
    ifA.wire_rdy_in = 1'b0;
    ifB.req = '0; ifB.in_wen = '0; ifB.in_data = '0; ifB.in_ctl = '0; ifB.in_fsrate = '0;
    ifB.wire_rdy_in = 1'b0;
    tick(2);
    armed = 1'b1;
    chk("A_reset_gnt", 32'(ifA.gnt), 32'd0);
    chk("B_reset_owner", 32'(ifB.owner), 32'd0);

    // Fixed priority, both requesting as reset releases.
    rst = 1'b0; ifA.req = 2'b11;
    tick; chk("A_init_no_gnt", 32'(ifA.gnt), 32'd0);
    tick; chk("A_first_gnt", 32'(ifA.gnt), 32'b01);
    chk("A_first_owner", 32'(ifA.owner), 32'd0);
    ifA.req = 2'b10;
    tick; chk("A_release_gnt", 32'(ifA.gnt), 32'd0);
    tick; chk("A_next_gnt", 32'(ifA.gnt), 32'b10);
    chk("A_next_owner", 32'(ifA.owner), 32'd1);
    ifA.req = 2'b00;
    tick;

    // Mux and write-enable gating on requester 2.
    ifB.in_data = 8'b00_10_00_00; ifB.in_ctl = 4'b0100; ifB.in_wen = 4'b0100;
    ifB.req = 4'b0100;
    tick; chk("B_mux_gnt", 32'(ifB.gnt), 32'b0100);
    chk("B_mux_bits", 32'(ifB.tx_bits), 32'd2);
    chk("B_mux_ctl", 32'(ifB.tx_ctl), 32'd1);
    chk("B_mux_wen", 32'(ifB.wire_wen), 32'd1);
    ifB.req = 4'b0000;
    tick; chk("B_gated_gnt", 32'(ifB.gnt), 32'd0);
    chk("B_gated_wen", 32'(ifB.wire_wen), 32'd0);
    chk("B_idle_bits", 32'(ifB.tx_bits), 32'd2);

    // Hold timeout and lockout; pointer is 2, so requester 1 wins first.
    ifB.req = 4'b0110;
    tick; chk("B_to_gnt1", 32'(ifB.gnt), 32'b0010);
    tick(4); chk("B_to_gnt1_c5", 32'(ifB.gnt), 32'b0010);
    chk("B_to_no_pulse", 32'(ifB.hold_timeout), 32'd0);
    tick; chk("B_to_revoke", 32'(ifB.gnt), 32'd0);
    chk("B_to_pulse", 32'(ifB.hold_timeout), 32'd1);
    tick; chk("B_to_gnt2", 32'(ifB.gnt), 32'b0100);
    chk("B_to_pulse_once", 32'(ifB.hold_timeout), 32'd0);
    tick(5); chk("B_to2_pulse", 32'(ifB.hold_timeout), 32'd1);
    tick(4); chk("B_locked_out", 32'(ifB.gnt), 32'd0);
    ifB.req = 4'b0100;
    tick; chk("B_drop_gnt", 32'(ifB.gnt), 32'd0);
    ifB.req = 4'b0110;
    tick; chk("B_regrant1", 32'(ifB.gnt), 32'b0010);
    ifB.req = 4'b0000;
    tick(2);

    // Park the pointer at 3, then round-robin through all four.
    ifB.req = 4'b1000;
    tick; ifB.req = 4'b0000;
    tick(2);
    ifB.req = 4'b1111;
    tick; chk("B_rr_first", 32'(ifB.gnt), 32'b0001);
    for (int g = 0; g < 4; g++) begin
      tick(2);
      ifB.req[order[g]] = 1'b0;
      tick; chk("B_rr_gap", 32'(ifB.gnt), 32'd0);
      ifB.req[order[g]] = 1'b1;
      tick; chk("B_rr_next", 32'(ifB.gnt), 32'(1 << order[g+1]));
      chk("B_rr_owner", 32'(ifB.owner), 32'(order[g+1]));
    end

    // Reset in the middle of a transfer owned by requester 3.
    ifB.req = 4'b1000;
    tick; tick; chk("B_pre_rst_gnt", 32'(ifB.gnt), 32'b1000);
    rst = 1'b1;
    tick; chk("B_rst_gnt", 32'(ifB.gnt), 32'd0);
    chk("B_rst_owner", 32'(ifB.owner), 32'd0);
    chk("B_rst_to", 32'(ifB.hold_timeout), 32'd0);
    rst = 1'b0;
    tick; chk("B_post_rst_init", 32'(ifB.gnt), 32'd0);
    tick; chk("B_post_rst_gnt", 32'(ifB.gnt), 32'b1000);

    // Sticky random requests with random payloads, ready and occasional reset.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) ifA.req[$urandom_range(0, 1)] ^= 1'b1;
      if ($urandom_range(0, 2) == 0) ifB.req[$urandom_range(0, 3)] ^= 1'b1;
      ifA.in_wen = 2'($urandom); ifA.in_data = 4'($urandom);
      ifA.in_ctl = 2'($urandom); ifA.in_fsrate = 2'($urandom);
      ifB.in_wen = 4'($urandom); ifB.in_data = 8'($urandom);
      ifB.in_ctl = 4'($urandom); ifB.in_fsrate = 4'($urandom);
      ifA.wire_rdy_in = 1'($urandom); ifB.wire_rdy_in = 1'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick;
    end
    rst = 1'b0;
    tick(2);
    armed = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
